// File: rtl/merge_pkg.sv
// Shared types and helpers for the two-way streaming merge stage.
//
// Contents:
//   merge_state_t : FSM state encoding for merge2_stream.
//   CMP_W         : widest element width the comparator helper accepts.
//   take_a()      : merge ordering decision. Ties favour A, which keeps the merge stable.
package merge_pkg;

  // take_a() compares zero-extended operands at this width.
  // Element widths up to CMP_W bits are supported.
  localparam int unsigned CMP_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MERGE   = 3'd1,
    DRAIN_A = 3'd2,
    DRAIN_B = 3'd3,
    DONE    = 3'd4
  } merge_state_t;

  // Returns 1 when the head of A must be emitted before the head of B.
  // Equal keys return 1 in both directions, so A always wins a tie.
  function automatic logic take_a(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b,
                                  input logic             descending);
    return descending ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/merge_sel.sv
// Comparator and data mux of the merge stage.
//
// Ports:
//   a_data_i, b_data_i : heads of FIFO A and FIFO B.
//   descending_i       : order select latched for the current run pair.
//   force_a_i          : draining A, so the comparison is ignored.
//   force_b_i          : draining B, so the comparison is ignored.
//   sel_a_o            : 1 selects A, 0 selects B.
//   out_data_o         : selected head.
module merge_sel
  import merge_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              descending_i,
  input  logic              force_a_i,
  input  logic              force_b_i,
  output logic              sel_a_o,
  output logic [DATA_W-1:0] out_data_o
);

  always_comb begin
    sel_a_o = 1'b0;
    if (force_a_i) begin
      sel_a_o = 1'b1;
    end else if (force_b_i) begin
      sel_a_o = 1'b0;
    end else begin
      sel_a_o = take_a(CMP_W'(a_data_i), CMP_W'(b_data_i), descending_i);
    end
  end

  assign out_data_o = sel_a_o ? a_data_i : b_data_i;

endmodule

// File: rtl/merge2_stream.sv
// Two-way streaming merge stage.
//
// The stage merges two pre-sorted runs of run_len elements each.
// The runs come from first-word-fall-through FIFOs A and B.
// The result is one sorted run of 2*run_len elements written to an output FIFO.
//
// Ports:
//   clk, rst          : clock; synchronous active-high reset.
//   start             : request one run-pair merge. Sampled only in IDLE.
//   run_len           : elements per input run, 0..MAX_RUN. Sampled with start.
//   descending        : 0 = ascending, 1 = descending. Sampled with start.
//   a_data/a_empty    : head and empty flag of FIFO A.
//   a_rd              : pop FIFO A.
//   b_data/b_empty    : head and empty flag of FIFO B.
//   b_rd              : pop FIFO B.
//   out_data/out_wr   : element and write strobe for the output FIFO.
//   out_full          : output FIFO cannot accept a write this cycle.
//   busy              : registered. High from the cycle after an accepted start until DONE exits.
//   done              : registered one-cycle pulse while in DONE.
module merge2_stream
  import merge_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_RUN = 256,
  parameter int CNT_W   = $clog2(MAX_RUN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_len,
  input  logic              descending,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_empty,
  output logic              a_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_empty,
  output logic              b_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr,
  input  logic              out_full,
  output logic              busy,
  output logic              done
);

  merge_state_t     state_q, state_d;
  logic [CNT_W-1:0] a_left_q, a_left_d;
  logic [CNT_W-1:0] b_left_q, b_left_d;
  logic             desc_q, desc_d;
  logic             busy_q, done_q;

  logic              a_rd_c, b_rd_c, wr_c;
  logic              sel_a;
  logic [DATA_W-1:0] sel_data;

  merge_sel #(
    .DATA_W (DATA_W)
  ) u_sel (
    .a_data_i     (a_data),
    .b_data_i     (b_data),
    .descending_i (desc_q),
    .force_a_i    (state_q == DRAIN_A),
    .force_b_i    (state_q == DRAIN_B),
    .sel_a_o      (sel_a),
    .out_data_o   (sel_data)
  );

  always_comb begin
    state_d  = state_q;
    a_left_d = a_left_q;
    b_left_d = b_left_q;
    desc_d   = desc_q;
    a_rd_c   = 1'b0;
    b_rd_c   = 1'b0;
    wr_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_left_d = run_len;
          b_left_d = run_len;
          desc_d   = descending;
          state_d  = (run_len == '0) ? DONE : MERGE;
        end
      end

      MERGE: begin
        // Both heads are needed for the comparison.
        // An empty FIFO on either side stalls the merge.
        // The counter guards keep a pop from ever happening at a zero count.
        if (!a_empty && !b_empty && !out_full &&
            (a_left_q != '0) && (b_left_q != '0)) begin
          wr_c = 1'b1;
          if (sel_a) begin
            a_rd_c   = 1'b1;
            a_left_d = a_left_q - CNT_W'(1);
            if (a_left_q == CNT_W'(1)) state_d = DRAIN_B;
          end else begin
            b_rd_c   = 1'b1;
            b_left_d = b_left_q - CNT_W'(1);
            if (b_left_q == CNT_W'(1)) state_d = DRAIN_A;
          end
        end
      end

      DRAIN_A: begin
        if (a_left_q == '0) begin
          state_d = DONE;
        end else if (!a_empty && !out_full) begin
          wr_c     = 1'b1;
          a_rd_c   = 1'b1;
          a_left_d = a_left_q - CNT_W'(1);
          if (a_left_q == CNT_W'(1)) state_d = DONE;
        end
      end

      DRAIN_B: begin
        if (b_left_q == '0) begin
          state_d = DONE;
        end else if (!b_empty && !out_full) begin
          wr_c     = 1'b1;
          b_rd_c   = 1'b1;
          b_left_d = b_left_q - CNT_W'(1);
          if (b_left_q == CNT_W'(1)) state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset masks the strobes in the same cycle it is asserted.
  // This keeps a mid-merge reset from popping a FIFO whose state is about to be discarded.
  assign a_rd     = a_rd_c & ~rst;
  assign b_rd     = b_rd_c & ~rst;
  assign out_wr   = wr_c & ~rst;
  assign out_data = out_wr ? sel_data : '0;

  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_left_q <= '0;
      b_left_q <= '0;
      desc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_left_q <= a_left_d;
      b_left_q <= b_left_d;
      desc_q   <= desc_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

endmodule
